// File: rtl/fetch_queue.sv
// fetch_queue: receiving end of fetch->decode. Buffers fetched instructions and their
// prediction metadata in a small FIFO, back-pressures fetch with freeze and presents
// the head to decode with valid/ready. The head is predecoded for JAL so that a JAL
// that fetch did not steer to can redirect early from decode.
module fetch_queue #(
  parameter int WIDTH = 31,  // MSB of instruction/address
  parameter int INDEX = 7,   // MSB of gshare index
  parameter int DEPTH = 4,   // entries, power of two
  parameter int PTR   = 1    // MSB of pointers, log2(DEPTH)-1
) (
  input  logic             clk,
  input  logic             globalResetN,
  input  logic             flush,
  input  logic [WIDTH:0]   instr,
  input  logic [WIDTH:0]   instrPC,
  input  logic [WIDTH:0]   predictedPCF,
  input  logic [INDEX:0]   GHRIndex,
  input  logic [1:0]       PHTState,
  input  logic             redirect,
  output logic             freeze,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH:0]   outInstr,
  output logic [WIDTH:0]   outPC,
  output logic [WIDTH:0]   outPredictedPC,
  output logic [INDEX:0]   outGHRIndex,
  output logic [1:0]       outPHTState,
  output logic             outRedirect,
  output logic             isJAL,
  output logic [WIDTH:0]   validAddress,
  output logic [WIDTH:0]   decodePC,
  output logic             earlyMisdirect
);

  typedef struct packed {
    logic [WIDTH:0] instr;
    logic [WIDTH:0] pc;
    logic [WIDTH:0] ppc;
    logic [INDEX:0] ghr;
    logic [1:0]     pht;
    logic           redir;
  } entry_t;

  localparam logic [6:0]     OP_JAL = 7'b1101111;
  localparam logic [PTR+1:0] FULL   = (PTR+2)'(DEPTH);
  localparam logic [PTR:0]   P_ONE  = (PTR+1)'(1);
  localparam logic [PTR+1:0] C_ONE  = (PTR+2)'(1);

  entry_t         mem_q [DEPTH];
  logic [PTR:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR+1:0] count_q, count_d;

  entry_t         head, in_entry;
  logic [WIDTH:0] jimm;
  logic           enq, deq, wr_en, mis_jal;

  // Freeze looks at occupancy only, so a dequeue never opens a same-cycle slot.
  assign freeze   = (count_q == FULL);
  assign outValid = (count_q != '0);
  assign enq      = !freeze && (instr != '0);
  assign deq      = outValid && outReady;

  assign in_entry = '{instr: instr, pc: instrPC, ppc: predictedPCF,
                      ghr: GHRIndex, pht: PHTState, redir: redirect};

  // Head read; forced to zero when empty so stale storage never leaks to decode.
  always_comb begin
    head = '0;
    if (outValid) head = mem_q[rd_ptr_q];
  end

  assign outInstr       = head.instr;
  assign outPC          = head.pc;
  assign outPredictedPC = head.ppc;
  assign outGHRIndex    = head.ghr;
  assign outPHTState    = head.pht;
  assign outRedirect    = head.redir;
  assign decodePC       = head.pc;

  // JAL predecode: J-type immediate, target relative to the head PC.
  assign jimm = {{(WIDTH-19){head.instr[WIDTH]}}, head.instr[19:12], head.instr[20],
                 head.instr[30:21], 1'b0};
  assign validAddress = head.pc + jimm;
  assign isJAL        = outValid && (head.instr[6:0] == OP_JAL);

  // Fetch got it right only if it redirected and to exactly the JAL target.
  assign mis_jal        = !head.redir || (head.ppc != validAddress);
  assign earlyMisdirect = globalResetN && !flush && deq && isJAL && mis_jal;

  // A write only lands when neither flush nor an early redirect discards it.
  assign wr_en = enq && !flush && !earlyMisdirect;

  // Next-state pointers and occupancy with flush > early redirect > enq/deq.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush || earlyMisdirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + P_ONE;
      if (deq) rd_ptr_d = rd_ptr_q + P_ONE;
      case ({enq, deq})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State update; reset also clears storage so every head field reads zero.
  always_ff @(posedge clk) begin
    if (!globalResetN) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (wr_en) mem_q[wr_ptr_q] <= in_entry;
    end
  end

endmodule
